// File: rtl/pc_gate_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pc_gate_seq: gated pulse/low-period counter, internal or PPS gate.     |
// | Optional PC_GATE_SUBSAMPLE_EN: fractional internal gate extension.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pc_gate_seq #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             enable,
  input  logic             use_one_pps_in,
  input  logic [31:0]      clk_freq,
  input  logic [31:0]      clk_subsample,
  input  logic             one_pps_in,
  input  logic             pulse_in,
  input  logic             rd_ack,
  output logic [CNT_W-1:0] pulse_per_second,
  output logic [ACC_W-1:0] accum_low_period,
  output logic             ready_to_read,
  output logic             overrun,
  output logic             gate_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             pps_prev;
  logic             pulse_prev;
  logic             mode_prev;
  logic [CNT_W-1:0] edge_cnt;
  logic [ACC_W-1:0] low_cnt;
  logic [31:0]      gate_cnt;
  logic [31:0]      gate_last;
  logic [31:0]      base_last;
  logic             pps_rise;
  logic             pulse_rise;
  logic             mode_chg;
  logic             gate_end;
  logic             gate_start;
  logic             ext;

  assign pps_rise   = one_pps_in & ~pps_prev;
  assign pulse_rise = pulse_in & ~pulse_prev;
  assign mode_chg   = use_one_pps_in ^ mode_prev;
  assign gate_end   = use_one_pps_in ? pps_rise : (gate_cnt == gate_last);
  assign base_last  = (clk_freq == 32'd0) ? 32'd0 : clk_freq - 32'd1;

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else if (state != IDLE && mode_chg) begin
      state_nxt = ARM;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (!use_one_pps_in || pps_rise) state_nxt = GATE;
        GATE:    if (gate_end) state_nxt = LATCH;
        LATCH:   state_nxt = GATE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Entry into GATE from ARM or LATCH is where gate parameters are sampled.
  assign gate_start = (state_nxt == GATE) && (state != GATE);

`ifdef PC_GATE_SUBSAMPLE_EN
  logic [31:0] frac_acc;
  logic [32:0] frac_sum;

  // The first gate after ARM starts from a zero fraction.
  assign frac_sum = {1'b0, (state == LATCH) ? frac_acc : 32'd0} + {1'b0, clk_subsample};
  assign ext      = frac_sum[32] & ~use_one_pps_in;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      frac_acc <= 32'd0;
    end else if (gate_start && !use_one_pps_in) begin
      frac_acc <= frac_sum[31:0];
    end else if (state == IDLE || state == ARM) begin
      frac_acc <= 32'd0;
    end
  end
`else
  logic [31:0] unused_subsample;
  assign unused_subsample = clk_subsample;
  assign ext              = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state            <= IDLE;
      gate_active      <= 1'b0;
      pps_prev         <= 1'b1;
      pulse_prev       <= 1'b1;
      mode_prev        <= 1'b0;
      edge_cnt         <= '0;
      low_cnt          <= '0;
      gate_cnt         <= 32'd0;
      gate_last        <= 32'd0;
      pulse_per_second <= '0;
      accum_low_period <= '0;
      ready_to_read    <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      state       <= state_nxt;
      gate_active <= (state_nxt == GATE);
      pps_prev    <= one_pps_in;
      pulse_prev  <= pulse_in;
      mode_prev   <= use_one_pps_in;

      if (gate_start) begin
        gate_last <= base_last + {31'd0, ext};
      end

      if (state == GATE) begin
        gate_cnt <= gate_cnt + 32'd1;
        if (pulse_rise && edge_cnt != '1) edge_cnt <= edge_cnt + CNT_W'(1);
        if (!pulse_in && low_cnt != '1) low_cnt <= low_cnt + ACC_W'(1);
      end else begin
        gate_cnt <= 32'd0;
        edge_cnt <= '0;
        low_cnt  <= '0;
      end

      if (rd_ack) begin
        ready_to_read <= 1'b0;
        overrun       <= 1'b0;
      end

      // An abort (enable low or mode change) during LATCH also drops the result.
      if (state == LATCH && state_nxt == GATE) begin
        pulse_per_second <= edge_cnt;
        accum_low_period <= low_cnt;
        ready_to_read    <= 1'b1;
        overrun          <= ready_to_read & ~rd_ack;
      end
    end
  end

endmodule
`default_nettype wire
